// File: rtl/shift_request_arbiter_pkg.sv
// Shared types and sizing helpers for the shift request arbiter.
// No logic; latency and backpressure are defined by the modules that import it.
package shift_arb_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    // Requester id width; a two-way arbiter still needs one id bit.
    function automatic int id_width(input int r);
        return (r <= 2) ? 1 : $clog2(r);
    endfunction

endpackage

// File: rtl/shift_request_arbiter_if.sv
// Requester bundle plus tagged result port of the shift request arbiter.
// Valid/ready on both sides; the master side drives requests and the sink ready.
interface shift_request_arbiter_if #(
    parameter int N = 3,
    parameter int R = 4
);
    import shift_arb_pkg::*;

    localparam int W  = 2 ** N;
    localparam int IW = id_width(R);

    logic [R-1:0]   req_valid;
    logic [R*W-1:0] req_data;
    logic [R*N-1:0] req_amt;
    logic [R-1:0]   req_lr;
    logic [R-1:0]   req_ready;

    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [IW-1:0]  out_id;
    logic           out_ready;
    logic [15:0]    op_count;

    modport master (
        output req_valid, req_data, req_amt, req_lr, out_ready,
        input  req_ready, out_valid, out_data, out_id, op_count
    );

    modport slave (
        input  req_valid, req_data, req_amt, req_lr, out_ready,
        output req_ready, out_valid, out_data, out_id, op_count
    );

endinterface

// File: rtl/shift_request_arbiter_rot.sv
// Combinational W-bit rotator: log-stage right rotate, with left rotate done by
// reversing bits before and after the right-rotate stages.
module multi_barrel_shifter_reverser #(
    parameter int N = 3,
    parameter int W = 2 ** N
) (
    input  logic [W-1:0] data,
    input  logic [N-1:0] amt,
    input  logic         lr,
    output logic [W-1:0] result
);

    logic [W-1:0] pre;
    logic [W-1:0] rot;
    logic [W-1:0] rev_in;
    logic [W-1:0] rev_rot;

    always_comb begin
        for (int k = 0; k < W; k++) begin
            rev_in[k] = data[W-1-k];
        end
        pre = lr ? rev_in : data;
    end

    always_comb begin
        rot = pre;
        for (int b = 0; b < N; b++) begin
            if (amt[b]) begin
                rot = (rot >> (1 << b)) | (rot << (W - (1 << b)));
            end
        end
    end

    always_comb begin
        for (int k = 0; k < W; k++) begin
            rev_rot[k] = rot[W-1-k];
        end
        result = lr ? rev_rot : rot;
    end

endmodule

// File: rtl/shift_request_arbiter_rr.sv
// Round-robin one-hot grant searching upward from ptr with wrap; purely combinational.
// en gates the grant only, so idx stays meaningful for datapath muxing regardless of stall.
module rr_arbiter
    import shift_arb_pkg::*;
#(
    parameter int R  = 4,
    parameter int IW = id_width(R)
) (
    input  logic [R-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          en,
    output logic [R-1:0]  grant,
    output logic [IW-1:0] idx
);

    always_comb begin
        logic found;
        int   cand;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int j = 0; j < R; j++) begin
            cand = (int'(ptr) + j) % R;
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = en;
                idx         = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/shift_request_arbiter.sv
// R requesters share one rotator; result registered one cycle after accept, 1 op/cycle.
// A held result stalls all requesters until the sink takes it; drain and refill share an edge.
module shift_request_arbiter
    import shift_arb_pkg::*;
#(
    parameter int N = 3,
    parameter int R = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    shift_request_arbiter_if.slave bus
);

    localparam int W  = 2 ** N;
    localparam int IW = id_width(R);

    state_t        state;
    state_t        state_n;
    logic [IW-1:0] ptr;
    logic [W-1:0]  data_q;
    logic [IW-1:0] id_q;
    logic [15:0]   count_q;

    logic          slot_free;
    logic [R-1:0]  grant;
    logic [IW-1:0] idx;
    logic          accept;
    logic          drain;
    logic [W-1:0]  sel_data;
    logic [N-1:0]  sel_amt;
    logic          sel_lr;
    logic [W-1:0]  rot_data;

    assign slot_free = (state == EMPTY) || bus.out_ready;

    // Reset gates the enable so nothing is acknowledged while reset_n is low.
    rr_arbiter #(.R(R), .IW(IW)) u_arb (
        .req   (bus.req_valid),
        .ptr   (ptr),
        .en    (slot_free && reset_n),
        .grant (grant),
        .idx   (idx)
    );

    assign accept = |grant;
    assign drain  = (state == FULL) && bus.out_ready;

    assign sel_data = bus.req_data[int'(idx) * W +: W];
    assign sel_amt  = bus.req_amt[int'(idx) * N +: N];
    assign sel_lr   = bus.req_lr[idx];

    multi_barrel_shifter_reverser #(.N(N), .W(W)) u_rot (
        .data   (sel_data),
        .amt    (sel_amt),
        .lr     (sel_lr),
        .result (rot_data)
    );

    always_comb begin
        state_n = state;
        case (state)
            EMPTY: if (accept) state_n = FULL;
            FULL: begin
                if (accept)
                    state_n = FULL;
                else if (bus.out_ready)
                    state_n = EMPTY;
            end
            default: state_n = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= EMPTY;
            ptr     <= '0;
            data_q  <= '0;
            id_q    <= '0;
            count_q <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                data_q <= rot_data;
                id_q   <= idx;
                ptr    <= (idx == IW'(R - 1)) ? '0 : idx + 1'b1;
            end
            if (drain) begin
                count_q <= count_q + 16'd1;
            end
        end
    end

    assign bus.req_ready = grant;
    assign bus.out_valid = (state == FULL);
    assign bus.out_data  = data_q;
    assign bus.out_id    = id_q;
    assign bus.op_count  = count_q;

endmodule

// File: tb/tb_shift_request_arbiter.sv
// Directed bench for shift_request_arbiter (N=3, R=4): reset, rotate, round robin,
// backpressure, wrap/skip and mid-operation reset.
module tb_shift_request_arbiter;

    logic clk;
    logic reset_n;
    int   checks;
    int   errors;

    shift_request_arbiter_if #(.N(3), .R(4)) bus ();

    shift_request_arbiter #(.N(3), .R(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [7:0] d, input logic [2:0] a, input logic l);
        bus.req_data[i*8 +: 8] = d;
        bus.req_amt[i*3 +: 3]  = a;
        bus.req_lr[i]          = l;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [7:0] d,
                             input logic [1:0] id, input logic [15:0] cnt);
        check({tag, "_valid"}, 16'(bus.out_valid), 16'(v));
        check({tag, "_data"},  16'(bus.out_data),  16'(d));
        check({tag, "_id"},    16'(bus.out_id),    16'(id));
        check({tag, "_count"}, bus.op_count,       cnt);
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        reset_n       = 1'b0;
        bus.req_valid = 4'b1111;
        bus.req_data  = '0;
        bus.req_amt   = '0;
        bus.req_lr    = '0;
        bus.out_ready = 1'b1;

        // 1. reset held three clocks with every requester valid
        for (int c = 0; c < 3; c++) begin
            tick();
            check("rst_ready", 16'(bus.req_ready), 16'h0);
        end
        check_out("rst", 1'b0, 8'h00, 2'd0, 16'd0);

        // 2. single requester, rotate variants
        reset_n       = 1'b1;
        bus.req_valid = 4'b0001;
        set_req(0, 8'h81, 3'd1, 1'b1);
        #1;
        check("single_ready", 16'(bus.req_ready), 16'h1);
        tick();
        check_out("rotl1", 1'b1, 8'h03, 2'd0, 16'd0);
        set_req(0, 8'h81, 3'd1, 1'b0);
        tick();
        check_out("rotr1", 1'b1, 8'hC0, 2'd0, 16'd1);
        set_req(0, 8'h81, 3'd0, 1'b0);
        tick();
        check_out("amt0", 1'b1, 8'h81, 2'd0, 16'd2);
        bus.req_valid = 4'b0000;
        tick();
        check_out("drain_hold", 1'b0, 8'h81, 2'd0, 16'd3);

        // short reset returns the pointer to 0 and clears the counter
        reset_n = 1'b0;
        tick();
        check_out("rst2", 1'b0, 8'h00, 2'd0, 16'd0);

        // 3. round robin with all requesters valid
        reset_n = 1'b1;
        set_req(0, 8'h01, 3'd1, 1'b1);
        set_req(1, 8'h80, 3'd3, 1'b1);
        set_req(2, 8'hF0, 3'd4, 1'b0);
        set_req(3, 8'h96, 3'd2, 1'b0);
        bus.req_valid = 4'b1111;
        #1;
        check("rr_ready0", 16'(bus.req_ready), 16'h1);
        tick();
        check_out("rr0", 1'b1, 8'h02, 2'd0, 16'd0);
        tick();
        check_out("rr1", 1'b1, 8'h04, 2'd1, 16'd1);
        tick();
        check_out("rr2", 1'b1, 8'h0F, 2'd2, 16'd2);
        tick();
        check_out("rr3", 1'b1, 8'hA5, 2'd3, 16'd3);
        tick();
        check_out("rr4", 1'b1, 8'h02, 2'd0, 16'd4);
        tick();
        check_out("rr5", 1'b1, 8'h04, 2'd1, 16'd5);

        // 4. backpressure for four clocks, then release without a bubble
        bus.out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            check("bp_ready", 16'(bus.req_ready), 16'h0);
            tick();
            check_out("bp_hold", 1'b1, 8'h04, 2'd1, 16'd5);
        end
        bus.out_ready = 1'b1;
        #1;
        check("bp_release_ready", 16'(bus.req_ready), 16'h4);
        tick();
        check_out("bp_release", 1'b1, 8'h0F, 2'd2, 16'd6);

        // 5. pointer at 3 with sparse requests: wraps to 0, then skips to 2
        bus.req_valid = 4'b0101;
        #1;
        check("wrap_ready", 16'(bus.req_ready), 16'h1);
        tick();
        check_out("wrap0", 1'b1, 8'h02, 2'd0, 16'd7);
        #1;
        check("skip_ready", 16'(bus.req_ready), 16'h4);
        tick();
        check_out("skip2", 1'b1, 8'h0F, 2'd2, 16'd8);
        bus.req_valid = 4'b0000;
        tick();
        check_out("idle", 1'b0, 8'h0F, 2'd2, 16'd9);

        // 6. reset while a result is held under backpressure
        bus.req_valid = 4'b0010;
        bus.out_ready = 1'b0;
        tick();
        check_out("pre_rst", 1'b1, 8'h04, 2'd1, 16'd9);
        reset_n       = 1'b0;
        bus.req_valid = 4'b1010;
        #1;
        check("midrst_ready", 16'(bus.req_ready), 16'h0);
        tick();
        check_out("midrst", 1'b0, 8'h00, 2'd0, 16'd0);
        reset_n       = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        check("post_rst_ready", 16'(bus.req_ready), 16'h2);
        tick();
        check_out("post_rst", 1'b1, 8'h04, 2'd1, 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
